spi_ram_slave: RTL and testbench
================================

// Module: spi_ram_slave
// PURPOSE
//  SPI mode-0 slave exposing a parametrised byte RAM to the host MCU: command byte, address
//  byte, then an auto-incrementing burst of data bytes. Second port gives FPGA fabric reads
//  plus a write-notify strobe. Sits between the MCU SPI pins and application logic.
// PARAMETERS
//  ADDR_W     6      RAM address width, 1..8; depth = 2**ADDR_W bytes
//  WRAP       1      1: burst address wraps to 0 at end; 0: burst stops at last address
//  ACK_BYTE   8'h77  MISO value during address byte of a valid command
//  ID_BYTE    8'hA5  value streamed by ID command
// PORTS
//  clk        in   1       system clock; must be >= 8x SCK frequency
//  rst        in   1       synchronous, active-high reset
//  SCK        in   1       SPI clock, async; sample on rising edge, shift on falling edge
//  SSEL       in   1       SPI select, async, active low
//  MOSI       in   1       SPI data in, MSB first
//  MISO       out  1       SPI data out, MSB first
//  busy       out  1       1 while SSEL synchronised-active
//  wr_valid   out  1       1-clk pulse per committed SPI write
//  wr_addr    out  ADDR_W  address of committed write (valid with wr_valid)
//  wr_data    out  8       data of committed write (valid with wr_valid)
//  usr_addr   in   ADDR_W  fabric read address
//  usr_rdata  out  8       mem[usr_addr] registered, 1-clk latency
// BEHAVIOUR
//  - Sync: SCK, SSEL through 3-flop shift regs; MOSI through 2 flops. Edges detected on [2:1].
//  - Reset: MISO=0, busy=0, wr_valid=0, wr_addr=0, wr_data=0, usr_rdata=0, FSM=IDLE,
//    bitcnt=0. RAM contents NOT reset.
//  - FSM: IDLE -> CMD on SSEL falling edge. CMD -> ADDR after 8th rising edge if cmd is
//    01 WRITE, 02 READ, 9F ID; else -> SKIP. ADDR -> DATA after 8th rising edge, addr latched.
//    Any state -> IDLE when SSEL inactive (partial byte discarded, bitcnt=0).
//  - MISO bytes: during CMD 8'h00; during ADDR ACK_BYTE (valid cmd); SKIP 8'hFF for all.
//    DATA: READ -> mem[ptr]; WRITE -> 8'h00; ID -> ID_BYTE; exhausted (WRAP=0) -> 8'hFF.
//  - New byte loaded into shift reg on first SCK falling edge with bitcnt==0; otherwise
//    shift left, fill 0. First bit of byte 0 = MSB of 8'h00 (shift reg cleared on select).
//  - READ prefetch: mem[addr] fetched within 2 clk of address byte's 8th rising edge; each
//    data byte end fetches mem[ptr+1] before next falling edge (guaranteed by 8x clk ratio).
//  - WRITE: on 8th rising edge of each data byte, mem[ptr]<=byte; next clk wr_valid=1 with
//    wr_addr=ptr, wr_data=byte. No strobe for partial byte or exhausted WRAP=0 writes.
//  - Pointer: ptr+1 after each data byte, mod 2**ADDR_W if WRAP=1; if WRAP=0 at last
//    address set exhausted flag, drop further writes.
//  - Address byte: low ADDR_W bits used, upper bits ignored.
//  - Fabric read vs SPI write same address same clk: usr_rdata returns old data.
//  - rst mid-transaction: immediate IDLE; stays IDLE until next SSEL falling edge
//    (current selection ignored).
//  - busy = synchronised SSEL active (2 clk after pin), 0 under rst.
// TESTING
//  1 WRITE 01,04,11,22,33 -> mem[4..6]=11,22,33; 3 wr_valid pulses (addr 4,5,6); MISO 00,77,00,00,00
//  2 READ 02,04,xx,xx,xx after test 1 -> MISO 00,77,11,22,33; no wr_valid
//  3 ADDR_W=6 WRAP=1: WRITE 01,3F,AA,BB -> mem[63]=AA, mem[0]=BB; WRAP=0 -> mem[0] unchanged, 1 strobe
//  4 Unknown cmd 55,xx,xx -> MISO 00,FF,FF; RAM unchanged; ID 9F,00,xx -> MISO 00,77,A5
//  5 SSEL high after 5 bits of data byte -> no write/strobe; next READ returns old byte
//  6 rst pulse mid-burst -> MISO=0, busy=0 next clk; remaining bytes ignored until reselect

Source files
------------

// File: rtl/spi_ram_slave.sv
// spi_ram_slave: SPI mode-0 slave in front of a small byte RAM.
// The MCU sends a command byte, then an address byte, then a burst of data bytes.
// The address increments after each data byte. A second port lets the FPGA fabric
// read the RAM, and a one-cycle strobe reports every byte that SPI writes into it.
//
// Commands: 01 WRITE, 02 READ, 9F ID. Any other command byte is skipped, and MISO
// returns 8'hFF until the MCU releases select.
//
// Ports
//   i_clk        system clock; must run at least 8x the SCK frequency
//   i_rst        synchronous active-high reset
//   i_sck        SPI clock (async). MOSI is sampled on the rising edge; MISO shifts on the falling edge
//   i_ssel       SPI select (async), active low
//   i_mosi       SPI data in, MSB first
//   o_miso       SPI data out, MSB first
//   o_busy       high while the synchronised select is active
//   o_wr_valid   one-clock pulse for each committed SPI write
//   o_wr_addr    address of the committed write
//   o_wr_data    data of the committed write
//   i_usr_addr   fabric read address
//   o_usr_rdata  mem[i_usr_addr], registered, 1-clock latency
module spi_ram_slave #(
  parameter int unsigned ADDR_W   = 6,
  parameter bit          WRAP     = 1'b1,
  parameter logic [7:0]  ACK_BYTE = 8'h77,
  parameter logic [7:0]  ID_BYTE  = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_ssel,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_busy,
  output logic              o_wr_valid,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  input  logic [ADDR_W-1:0] i_usr_addr,
  output logic [7:0]        o_usr_rdata
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        CMD_WRITE = 8'h01;
  localparam logic [7:0]        CMD_READ  = 8'h02;
  localparam logic [7:0]        CMD_ID    = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_SKIP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [2:0]        r_sck_sync;
  logic [2:0]        r_ssel_sync;
  logic [1:0]        r_mosi_sync;

  logic [2:0]        r_bitcnt;
  logic [6:0]        r_rx;
  logic [7:0]        r_tx;
  logic [7:0]        r_cmd;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_exhausted;
  logic [7:0]        r_rd_data;
  logic [7:0]        r_mem [DEPTH];

  logic              w_sck_rise;
  logic              w_sck_fall;
  logic              w_ssel_active;
  logic              w_ssel_fall;
  logic              w_in_frame;
  logic              w_byte_done;
  logic [7:0]        w_rx_byte;
  logic              w_cmd_valid;
  logic              w_cmd_mem;
  logic              w_data_done;
  logic              w_mem_we;
  logic [7:0]        w_tx_load;

  // Bring the asynchronous pins into the clock domain; left unreset so that a
  // reset cannot fabricate a select edge.
  always_ff @(posedge i_clk) begin
    r_sck_sync  <= {r_sck_sync[1:0], i_sck};
    r_ssel_sync <= {r_ssel_sync[1:0], i_ssel};
    r_mosi_sync <= {r_mosi_sync[0], i_mosi};
  end

  // Edges are taken on the settled taps [2:1]. MOSI tap [1] lines up with SCK tap [1].
  assign w_sck_rise    = r_sck_sync[1] & ~r_sck_sync[2];
  assign w_sck_fall    = ~r_sck_sync[1] & r_sck_sync[2];
  assign w_ssel_active = ~r_ssel_sync[1];
  assign w_ssel_fall   = r_ssel_sync[2] & ~r_ssel_sync[1];

  assign w_in_frame  = w_ssel_active && (r_state != ST_IDLE);
  assign w_byte_done = w_in_frame && w_sck_rise && (r_bitcnt == 3'd7);
  assign w_rx_byte   = {r_rx, r_mosi_sync[1]};

  assign w_cmd_valid = (w_rx_byte == CMD_WRITE) || (w_rx_byte == CMD_READ) ||
                       (w_rx_byte == CMD_ID);
  assign w_cmd_mem   = (r_cmd == CMD_WRITE) || (r_cmd == CMD_READ);
  assign w_data_done = w_byte_done && (r_state == ST_DATA) && w_cmd_mem && !r_exhausted;
  assign w_mem_we    = !i_rst && w_data_done && (r_cmd == CMD_WRITE);

  assign o_miso = r_tx[7];

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic. Dropping select aborts from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_ssel_active) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: if (w_ssel_fall) w_state_nxt = ST_CMD;
        ST_CMD:  if (w_byte_done) w_state_nxt = w_cmd_valid ? ST_ADDR : ST_SKIP;
        ST_ADDR: if (w_byte_done) w_state_nxt = ST_DATA;
        ST_DATA: w_state_nxt = ST_DATA;
        ST_SKIP: w_state_nxt = ST_SKIP;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Byte that MISO presents next; chosen from the state the frame has reached.
  always_comb begin
    w_tx_load = 8'h00;
    unique case (r_state)
      ST_ADDR: w_tx_load = ACK_BYTE;
      ST_SKIP: w_tx_load = 8'hFF;
      ST_DATA: begin
        if (r_exhausted)           w_tx_load = 8'hFF;
        else if (r_cmd == CMD_READ) w_tx_load = r_rd_data;
        else if (r_cmd == CMD_ID)   w_tx_load = ID_BYTE;
        else                        w_tx_load = 8'h00;
      end
      default: w_tx_load = 8'h00;
    endcase
  end

  // Shift engine, command/pointer tracking and write strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bitcnt    <= 3'd0;
      r_rx        <= 7'd0;
      r_tx        <= 8'h00;
      r_cmd       <= 8'h00;
      r_ptr       <= '0;
      r_exhausted <= 1'b0;
      o_busy      <= 1'b0;
      o_wr_valid  <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= 8'h00;
    end else begin
      o_busy     <= w_ssel_active;
      o_wr_valid <= 1'b0;
      if (!w_in_frame) begin
        // Idle or deselected: discard any partial byte. The TX register is cleared,
        // so byte 0 shifts out 8'h00.
        r_bitcnt    <= 3'd0;
        r_rx        <= 7'd0;
        r_tx        <= 8'h00;
        r_exhausted <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_rx     <= w_rx_byte[6:0];
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        // The first falling edge after a byte boundary loads a fresh byte.
        if (w_sck_fall) begin
          if (r_bitcnt == 3'd0) r_tx <= w_tx_load;
          else                  r_tx <= {r_tx[6:0], 1'b0};
        end
        if (w_byte_done && (r_state == ST_CMD))  r_cmd <= w_rx_byte;
        if (w_byte_done && (r_state == ST_ADDR)) r_ptr <= w_rx_byte[ADDR_W-1:0];
        if (w_data_done) begin
          if (r_cmd == CMD_WRITE) begin
            o_wr_valid <= 1'b1;
            o_wr_addr  <= r_ptr;
            o_wr_data  <= w_rx_byte;
          end
          if (r_ptr != LAST_ADDR) r_ptr <= r_ptr + ADDR_W'(1);
          else if (WRAP)          r_ptr <= '0;
          else                    r_exhausted <= 1'b1;
        end
      end
    end
  end

  // RAM (not reset). The SPI write port also feeds a continuous prefetch of
  // mem[ptr], which is ready long before the next SCK falling edge.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_rx_byte;
    r_rd_data <= r_mem[r_ptr];
  end

  // Fabric read port. A write to the same address in the same clock returns the old data.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_usr_rdata <= 8'h00;
    else       o_usr_rdata <= r_mem[i_usr_addr];
  end

endmodule

// File: tb/tb_spi_ram_slave.sv
// tb_spi_ram_slave: directed bench for spi_ram_slave.
// Two instances share the SPI pins: u_dut_w has WRAP=1, u_dut_n has WRAP=0.
module tb_spi_ram_slave;

  localparam int AW   = 6;
  localparam int HALF = 8;

  logic          clk  = 1'b0;
  logic          rst  = 1'b1;
  logic          sck  = 1'b0;
  logic          ssel = 1'b1;
  logic          mosi = 1'b0;
  logic [AW-1:0] usr_addr = '0;

  logic          miso_a, busy_a, wv_a;
  logic [AW-1:0] wa_a;
  logic [7:0]    wd_a, rd_a;
  logic          miso_b, busy_b, wv_b;
  logic [AW-1:0] wa_b;
  logic [7:0]    wd_b, rd_b;

  int total = 0;
  int bad   = 0;

  int            nwr_a = 0;
  int            nwr_b = 0;
  logic [AW-1:0] la_a [16];
  logic [7:0]    ld_a [16];
  logic [AW-1:0] la_b [16];
  logic [7:0]    ld_b [16];

  logic [7:0] txq [8];
  logic [7:0] rxa [8];
  logic [7:0] rxb [8];

  always #5 clk = ~clk;

  spi_ram_slave #(.ADDR_W(AW), .WRAP(1'b1), .ACK_BYTE(8'h77), .ID_BYTE(8'hA5)) u_dut_w (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ssel(ssel), .i_mosi(mosi),
    .o_miso(miso_a), .o_busy(busy_a), .o_wr_valid(wv_a), .o_wr_addr(wa_a),
    .o_wr_data(wd_a), .i_usr_addr(usr_addr), .o_usr_rdata(rd_a)
  );

  spi_ram_slave #(.ADDR_W(AW), .WRAP(1'b0), .ACK_BYTE(8'h77), .ID_BYTE(8'hA5)) u_dut_n (
    .i_clk(clk), .i_rst(rst), .i_sck(sck), .i_ssel(ssel), .i_mosi(mosi),
    .o_miso(miso_b), .o_busy(busy_b), .o_wr_valid(wv_b), .o_wr_addr(wa_b),
    .o_wr_data(wd_b), .i_usr_addr(usr_addr), .o_usr_rdata(rd_b)
  );

  // Log every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (wv_a === 1'b1) begin
      if (nwr_a < 16) begin la_a[nwr_a] = wa_a; ld_a[nwr_a] = wd_a; end
      nwr_a = nwr_a + 1;
    end
    if (wv_b === 1'b1) begin
      if (nwr_b < 16) begin la_b[nwr_b] = wa_b; ld_b[nwr_b] = wd_b; end
      nwr_b = nwr_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, input int nbits,
                           output logic [7:0] ra, output logic [7:0] rb);
    ra = 8'h00;
    rb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      ra = {ra[6:0], miso_a};
      rb = {rb[6:0], miso_b};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] b3, input logic [7:0] b4);
    txq[0] = b0; txq[1] = b1; txq[2] = b2; txq[3] = b3; txq[4] = b4;
  endtask

  task automatic run_frame(input int n, input int last_bits);
    logic [7:0] ra, rb;
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      xfer_byte(txq[k], (k == n - 1) ? last_bits : 8, ra, rb);
      rxa[k] = ra;
      rxb[k] = rb;
    end
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic rdchk(input string tag, input logic [AW-1:0] a,
                       input logic [7:0] ea, input logic [7:0] eb);
    usr_addr = a;
    repeat (2) @(negedge clk);
    chk({tag, "_w"}, 32'(rd_a), 32'(ea));
    chk({tag, "_n"}, 32'(rd_b), 32'(eb));
  endtask

  initial begin
    logic [7:0] ra, rb;

    // Reset values while rst is held.
    repeat (5) @(negedge clk);
    chk("rst_miso",  32'(miso_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_wv",    32'(wv_a),   32'd0);
    chk("rst_waddr", 32'(wa_a),   32'd0);
    chk("rst_wdata", 32'(wd_a),   32'd0);
    chk("rst_urd",   32'(rd_a),   32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Test 1: WRITE 01,04,11,22,33.
    set_tx(8'h01, 8'h04, 8'h11, 8'h22, 8'h33);
    run_frame(5, 8);
    chk("t1_miso0", 32'(rxa[0]), 32'h00);
    chk("t1_miso1", 32'(rxa[1]), 32'h77);
    chk("t1_miso2", 32'(rxa[2]), 32'h00);
    chk("t1_miso4", 32'(rxa[4]), 32'h00);
    chk("t1_nwr",   32'(nwr_a),  32'd3);
    chk("t1_a0",    32'(la_a[0]), 32'h04);
    chk("t1_d0",    32'(ld_a[0]), 32'h11);
    chk("t1_a2",    32'(la_a[2]), 32'h06);
    chk("t1_d2",    32'(ld_a[2]), 32'h33);
    rdchk("t1_mem4", 6'd4, 8'h11, 8'h11);
    rdchk("t1_mem6", 6'd6, 8'h33, 8'h33);

    // Test 2: READ 02,04 returns the burst just written; no write strobes.
    set_tx(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
    run_frame(5, 8);
    chk("t2_miso0", 32'(rxa[0]), 32'h00);
    chk("t2_miso1", 32'(rxa[1]), 32'h77);
    chk("t2_miso2", 32'(rxa[2]), 32'h11);
    chk("t2_miso3", 32'(rxa[3]), 32'h22);
    chk("t2_miso4", 32'(rxa[4]), 32'h33);
    chk("t2_nwr",   32'(nwr_a),  32'd3);

    // Give mem[0] a known value before the wrap test.
    set_tx(8'h01, 8'h00, 8'h5A, 8'h00, 8'h00);
    run_frame(3, 8);
    chk("pre_nwr_w", 32'(nwr_a), 32'd4);

    // Test 3: WRITE 01,3F,AA,BB wraps to 0 with WRAP=1 and stops with WRAP=0.
    set_tx(8'h01, 8'h3F, 8'hAA, 8'hBB, 8'h00);
    run_frame(4, 8);
    chk("t3_nwr_w", 32'(nwr_a),   32'd6);
    chk("t3_nwr_n", 32'(nwr_b),   32'd5);
    chk("t3_a4_w",  32'(la_a[4]), 32'h3F);
    chk("t3_d4_w",  32'(ld_a[4]), 32'hAA);
    chk("t3_a5_w",  32'(la_a[5]), 32'h00);
    chk("t3_d5_w",  32'(ld_a[5]), 32'hBB);
    chk("t3_a4_n",  32'(la_b[4]), 32'h3F);
    rdchk("t3_mem63", 6'd63, 8'hAA, 8'hAA);
    rdchk("t3_mem0",  6'd0,  8'hBB, 8'h5A);
    set_tx(8'h02, 8'h3F, 8'h00, 8'h00, 8'h00);
    run_frame(4, 8);
    chk("t3_rd2_w", 32'(rxa[2]), 32'hAA);
    chk("t3_rd3_w", 32'(rxa[3]), 32'hBB);
    chk("t3_rd2_n", 32'(rxb[2]), 32'hAA);
    chk("t3_rd3_n", 32'(rxb[3]), 32'hFF);

    // Test 4: an unknown command is skipped; ID streams ID_BYTE.
    set_tx(8'h55, 8'h12, 8'h34, 8'h00, 8'h00);
    run_frame(3, 8);
    chk("t4_miso0", 32'(rxa[0]), 32'h00);
    chk("t4_miso1", 32'(rxa[1]), 32'hFF);
    chk("t4_miso2", 32'(rxa[2]), 32'hFF);
    chk("t4_nwr",   32'(nwr_a),  32'd6);
    rdchk("t4_mem4", 6'd4, 8'h11, 8'h11);
    set_tx(8'h9F, 8'h00, 8'h00, 8'h00, 8'h00);
    run_frame(3, 8);
    chk("t4_id0", 32'(rxa[0]), 32'h00);
    chk("t4_id1", 32'(rxa[1]), 32'h77);
    chk("t4_id2", 32'(rxa[2]), 32'hA5);

    // Test 5: select dropped 5 bits into a data byte; nothing is written.
    set_tx(8'h01, 8'h04, 8'hCC, 8'h00, 8'h00);
    run_frame(3, 5);
    chk("t5_nwr", 32'(nwr_a), 32'd6);
    set_tx(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
    run_frame(3, 8);
    chk("t5_rd", 32'(rxa[2]), 32'h11);

    // Test 6: reset in the middle of an ID burst; the rest of the selection is ignored.
    ssel = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer_byte(8'h9F, 8, ra, rb);
    xfer_byte(8'h00, 8, ra, rb);
    repeat (HALF) @(negedge clk);
    chk("t6_pre_miso", 32'(miso_a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_miso", 32'(miso_a), 32'd0);
    chk("t6_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    xfer_byte(8'h01, 8, ra, rb);
    chk("t6_ign0", 32'(ra), 32'h00);
    xfer_byte(8'h05, 8, ra, rb);
    xfer_byte(8'hEE, 8, ra, rb);
    chk("t6_ign2", 32'(ra), 32'h00);
    repeat (HALF) @(negedge clk);
    ssel = 1'b1;
    repeat (4 * HALF) @(negedge clk);
    chk("t6_nwr", 32'(nwr_a), 32'd6);
    rdchk("t6_mem5", 6'd5, 8'h22, 8'h22);

    // After reselect, normal service resumes; upper address bits are ignored (C5 -> 05).
    set_tx(8'h02, 8'hC5, 8'h00, 8'h00, 8'h00);
    run_frame(3, 8);
    chk("t6_rs1", 32'(rxa[1]), 32'h77);
    chk("t6_rs2", 32'(rxa[2]), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
